rom_ram_loader_ctrl: RTL and testbench

Sequences the boot-time copy of the ROM image from the slow ROM port into SRAM, one byte per transaction. While loading, it owns the RAM port. Once loading is complete, it hands the RAM port back to the CPU-side interface. It also supervises each ROM read with a timeout/retry scheme, accumulates a byte checksum, and reports busy/done/error status to the reset and boot logic.

---
 rtl/rom_ram_loader_ctrl_if.sv | 31 +++
 rtl/rom_ram_loader_ctrl.sv | 157 +++++++++++++++
 tb/tb_rom_ram_loader_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_ram_loader_ctrl_if.sv
// ROM read port, CPU-side RAM request and muxed RAM port of the boot loader.
// The loader side uses the master modport and the board/bench side uses slave.
interface rom_ram_loader_ctrl_if #(
   parameter int ADDR_W = 17
);
   // ROM handshake: rom_rden is a one-cycle read strobe. The ROM answers, at
   // some later cycle, with a one-cycle rom_data_ready pulse, and rom_datain is
   // valid only in that cycle. There is no backpressure on either side.
   logic              rom_rden;
   logic [ADDR_W-1:0] rom_address;
   logic              rom_data_ready;
   logic [7:0]        rom_datain;

   logic [ADDR_W-1:0] cpu_address;
   logic              cpu_wren;
   logic [7:0]        cpu_dataout;

   logic [ADDR_W-1:0] ram_address;
   logic              ram_wren;
   logic [7:0]        ram_dataout;

   modport master (
      output rom_rden, rom_address, ram_address, ram_wren, ram_dataout,
      input  rom_data_ready, rom_datain, cpu_address, cpu_wren, cpu_dataout
   );

   modport slave (
      input  rom_rden, rom_address, ram_address, ram_wren, ram_dataout,
      output rom_data_ready, rom_datain, cpu_address, cpu_wren, cpu_dataout
   );
endinterface

// File: rtl/rom_ram_loader_ctrl.sv
// Boot-time ROM-to-SRAM byte copier with per-byte timeout/retry and checksum.
// Owns the RAM port while busy, otherwise passes the CPU-side port through.
module rom_ram_loader_ctrl #(
   parameter int ADDR_W    = 17,
   parameter int LOAD_LEN  = 131072,
   parameter int BASE_ADDR = 0,
   parameter int TIMEOUT   = 255,
   parameter int MAX_RETRY = 3
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  start,
   rom_ram_loader_ctrl_if.master bus,
   output logic                  init_busy,
   output logic                  init_done,
   output logic                  init_error,
   output logic [7:0]            checksum,
   output logic [2:0]            o_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_WAIT  = 3'd2,
      S_WRITE = 3'd3,
      S_NEXT  = 3'd4,
      S_DONE  = 3'd5,
      S_ERROR = 3'd6
   } state_t;

   localparam logic [ADDR_W-1:0] LP_BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] LP_LAST      = ADDR_W'(LOAD_LEN - 1);
   localparam logic [7:0]        LP_TIMEOUT   = 8'(TIMEOUT);
   localparam logic [2:0]        LP_MAX_RETRY = 3'(MAX_RETRY);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
   logic [2:0]        r_retry, w_retry_nxt;
   logic [7:0]        r_timer, w_timer_nxt;
   logic [7:0]        r_byte, w_byte_nxt;
   logic [7:0]        r_checksum, w_checksum_nxt;
   logic              r_busy, w_busy_nxt;
   logic              r_done, w_done_nxt;
   logic              r_error, w_error_nxt;
   logic              r_rom_rden, w_rom_rden_nxt;
   logic [ADDR_W-1:0] w_addr;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_ptr_nxt      = r_ptr;
      w_retry_nxt    = r_retry;
      w_timer_nxt    = r_timer;
      w_byte_nxt     = r_byte;
      w_checksum_nxt = r_checksum;
      w_busy_nxt     = r_busy;
      w_done_nxt     = r_done;
      w_error_nxt    = r_error;
      case (r_state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               w_ptr_nxt      = '0;
               w_retry_nxt    = '0;
               w_checksum_nxt = '0;
               w_done_nxt     = 1'b0;
               w_error_nxt    = 1'b0;
               w_busy_nxt     = 1'b1;
               w_state_nxt    = S_REQ;
            end
         end
         S_REQ: begin
            w_timer_nxt = '0;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            // A ready pulse wins over a timeout landing in the same cycle.
            if (bus.rom_data_ready) begin
               w_byte_nxt  = bus.rom_datain;
               w_state_nxt = S_WRITE;
            end else if (r_timer == LP_TIMEOUT) begin
               if (r_retry < LP_MAX_RETRY) begin
                  w_retry_nxt = r_retry + 3'd1;
                  w_state_nxt = S_REQ;
               end else begin
                  w_busy_nxt  = 1'b0;
                  w_error_nxt = 1'b1;
                  w_state_nxt = S_ERROR;
               end
            end else begin
               w_timer_nxt = r_timer + 8'd1;
            end
         end
         S_WRITE: begin
            w_checksum_nxt = r_checksum + r_byte;
            w_state_nxt    = S_NEXT;
         end
         S_NEXT: begin
            w_retry_nxt = '0;
            if (r_ptr == LP_LAST) begin
               w_busy_nxt  = 1'b0;
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_ptr_nxt   = r_ptr + 1'b1;
               w_state_nxt = S_REQ;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_rom_rden_nxt = (w_state_nxt == S_REQ);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr      <= '0;
         r_retry    <= '0;
         r_timer    <= '0;
         r_byte     <= '0;
         r_checksum <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_rom_rden <= 1'b0;
      end else begin
         r_ptr      <= w_ptr_nxt;
         r_retry    <= w_retry_nxt;
         r_timer    <= w_timer_nxt;
         r_byte     <= w_byte_nxt;
         r_checksum <= w_checksum_nxt;
         r_busy     <= w_busy_nxt;
         r_done     <= w_done_nxt;
         r_error    <= w_error_nxt;
         r_rom_rden <= w_rom_rden_nxt;
      end
   end

   // Same offset on both sides; wraps modulo 2^ADDR_W.
   assign w_addr = LP_BASE + r_ptr;

   assign bus.rom_rden    = r_rom_rden;
   assign bus.rom_address = w_addr;

   assign bus.ram_address = r_busy ? w_addr                : bus.cpu_address;
   assign bus.ram_wren    = r_busy ? (r_state == S_WRITE)  : bus.cpu_wren;
   assign bus.ram_dataout = r_busy ? r_byte                : bus.cpu_dataout;

   assign init_busy  = r_busy;
   assign init_done  = r_done;
   assign init_error = r_error;
   assign checksum   = r_checksum;
   assign o_state    = r_state;

endmodule

// File: tb/tb_rom_ram_loader_ctrl.sv
// Directed bench for rom_ram_loader_ctrl: a behavioural ROM responder, a RAM
// write scoreboard and hand-computed expectations for each load scenario.
module tb_rom_ram_loader_ctrl;

   localparam int ADDR_W    = 17;
   localparam int LOAD_LEN  = 4;
   localparam int BASE_ADDR = 'h100;
   localparam int TIMEOUT   = 8;
   localparam int MAX_RETRY = 2;
   localparam int W         = ADDR_W + 8;

   logic       clock;
   logic       rst_n;
   logic       start;
   logic       init_busy;
   logic       init_done;
   logic       init_error;
   logic [7:0] checksum;
   logic [2:0] o_state;

   rom_ram_loader_ctrl_if #(.ADDR_W(ADDR_W)) bus();

   rom_ram_loader_ctrl #(
      .ADDR_W    (ADDR_W),
      .LOAD_LEN  (LOAD_LEN),
      .BASE_ADDR (BASE_ADDR),
      .TIMEOUT   (TIMEOUT),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .start      (start),
      .bus        (bus.master),
      .init_busy  (init_busy),
      .init_done  (init_done),
      .init_error (init_error),
      .checksum   (checksum),
      .o_state    (o_state)
   );

   int                n_chk = 0;
   int                n_err = 0;
   int                cyc   = 0;
   logic [W-1:0]      exp_q[$];
   logic [7:0]        rom_mem[4];
   int                skip[4];
   int                rsp_delay;
   int                rden_cyc_q[$];
   logic [ADDR_W-1:0] rden_addr_q[$];

   // clock / reset
   initial begin
      clock = 1'b0;
      forever begin
         #5 clock = 1'b1;
         cyc++;
         #5 clock = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ROM responder: answers rsp_delay cycles after a strobe unless told to skip it.
   initial begin
      int                cd;
      logic [7:0]        pd;
      logic [ADDR_W-1:0] off;
      cd = 0;
      pd = '0;
      bus.rom_data_ready = 1'b0;
      bus.rom_datain     = '0;
      forever begin
         @(negedge clock);
         bus.rom_data_ready = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) begin
               bus.rom_data_ready = 1'b1;
               bus.rom_datain     = pd;
            end
         end
         if (bus.rom_rden === 1'b1) begin
            rden_cyc_q.push_back(cyc);
            rden_addr_q.push_back(bus.rom_address);
            off = bus.rom_address - ADDR_W'(BASE_ADDR);
            if (off < ADDR_W'(4)) begin
               if (skip[int'(off)] > 0) skip[int'(off)]--;
               else begin
                  cd = rsp_delay;
                  pd = rom_mem[int'(off)];
               end
            end
         end
      end
   end

   // Scoreboard: every loader-side RAM write must match the next expected one.
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clock);
         if (init_busy === 1'b1 && bus.ram_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("ram_extra_write", 32'(bus.ram_wren), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("ram_wr_addr", 32'(bus.ram_address), 32'(e[W-1:8]));
               check("ram_wr_data", 32'(bus.ram_dataout), 32'(e[7:0]));
            end
         end
      end
   end

   task automatic load_rom(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input int n_push);
      rom_mem[0] = b0;
      rom_mem[1] = b1;
      rom_mem[2] = b2;
      rom_mem[3] = b3;
      for (int i = 0; i < n_push; i++)
         exp_q.push_back({ADDR_W'(BASE_ADDR + i), rom_mem[i]});
      rden_cyc_q.delete();
      rden_addr_q.delete();
   endtask

   task automatic drive_cpu(input logic [ADDR_W-1:0] a, input logic w, input logic [7:0] d);
      bus.cpu_address = a;
      bus.cpu_wren    = w;
      bus.cpu_dataout = d;
   endtask

   task automatic start_load();
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (init_done !== 1'b1 && init_error !== 1'b1 && n < 400) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(init_done | init_error), 32'd1);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      start     = 1'b0;
      rsp_delay = 1;
      for (int i = 0; i < 4; i++) skip[i] = 0;
      drive_cpu('0, 1'b0, '0);
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);

      // reset state and idle pass-through
      check("rst_busy",     32'(init_busy),       32'd0);
      check("rst_done",     32'(init_done),       32'd0);
      check("rst_error",    32'(init_error),      32'd0);
      check("rst_checksum", 32'(checksum),        32'd0);
      check("rst_rden",     32'(bus.rom_rden),    32'd0);
      check("rst_rom_addr", 32'(bus.rom_address), 32'h100);
      check("rst_state",    32'(o_state),         32'd0);
      drive_cpu(17'h01234, 1'b1, 8'h5A);
      #1;
      check("idle_pass_addr", 32'(bus.ram_address), 32'h01234);
      check("idle_pass_wren", 32'(bus.ram_wren),    32'd1);
      check("idle_pass_data", 32'(bus.ram_dataout), 32'h5A);
      drive_cpu('0, 1'b0, '0);

      // 1: ready two cycles after each strobe
      rsp_delay = 2;
      load_rom(8'h11, 8'h22, 8'h33, 8'h44, 4);
      start_load();
      wait_end("t1_end");
      check("t1_done",     32'(init_done),          32'd1);
      check("t1_busy",     32'(init_busy),          32'd0);
      check("t1_error",    32'(init_error),         32'd0);
      check("t1_checksum", 32'(checksum),           32'hAA);
      check("t1_pending",  32'(exp_q.size()),       32'd0);
      check("t1_rden_cnt", 32'(rden_addr_q.size()), 32'd4);
      check("t1_state",    32'(o_state),            32'd5);

      // 2: ready right after strobe, 4 cycles per byte
      rsp_delay = 1;
      load_rom(8'h01, 8'h02, 8'h03, 8'h04, 4);
      start_load();
      check("t2_busy_set",    32'(init_busy), 32'd1);
      check("t2_done_clr",    32'(init_done), 32'd0);
      check("t2_checksum_clr", 32'(checksum), 32'd0);
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      check("t2_cycles",   32'(n),        32'd16);
      check("t2_checksum", 32'(checksum), 32'h0A);
      check("t2_pending",  32'(exp_q.size()), 32'd0);

      // 3: byte 1 never answered, retries exhausted
      skip[1] = 100;
      load_rom(8'h10, 8'h20, 8'h30, 8'h40, 1);
      start_load();
      wait_end("t3_end");
      check("t3_error",    32'(init_error),         32'd1);
      check("t3_busy",     32'(init_busy),          32'd0);
      check("t3_done",     32'(init_done),          32'd0);
      check("t3_state",    32'(o_state),            32'd6);
      check("t3_rom_addr", 32'(bus.rom_address),    32'h101);
      check("t3_checksum", 32'(checksum),           32'h10);
      check("t3_pending",  32'(exp_q.size()),       32'd0);
      check("t3_rden_cnt", 32'(rden_addr_q.size()), 32'd4);
      if (rden_addr_q.size() == 4) begin
         for (int i = 1; i < 4; i++)
            check("t3_rden_addr", 32'(rden_addr_q[i]), 32'h101);
         check("t3_gap_a", 32'(rden_cyc_q[2] - rden_cyc_q[1]), 32'd10);
         check("t3_gap_b", 32'(rden_cyc_q[3] - rden_cyc_q[2]), 32'd10);
      end
      drive_cpu(17'h1ABCD, 1'b1, 8'h3C);
      #1;
      check("t3_pass_addr", 32'(bus.ram_address), 32'h1ABCD);
      check("t3_pass_wren", 32'(bus.ram_wren),    32'd1);
      check("t3_pass_data", 32'(bus.ram_dataout), 32'h3C);
      drive_cpu('0, 1'b0, '0);
      skip[1] = 0;

      // 4: byte 2 skipped once, byte 3 skipped twice (full budget)
      skip[2] = 1;
      skip[3] = 2;
      load_rom(8'hA0, 8'hB1, 8'hC2, 8'hD3, 4);
      start_load();
      wait_end("t4_end");
      check("t4_done",     32'(init_done),          32'd1);
      check("t4_error",    32'(init_error),         32'd0);
      check("t4_checksum", 32'(checksum),           32'hE6);
      check("t4_pending",  32'(exp_q.size()),       32'd0);
      check("t4_rden_cnt", 32'(rden_addr_q.size()), 32'd7);

      // 5: async reset while byte 2 is being read
      rsp_delay = 2;
      load_rom(8'h11, 8'h22, 8'h33, 8'h44, 2);
      start_load();
      n = 0;
      while (!(bus.rom_rden === 1'b1 && bus.rom_address === 17'h102) && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("t5_reach_byte2", 32'(bus.rom_address), 32'h102);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_busy",     32'(init_busy),       32'd0);
      check("t5_rst_done",     32'(init_done),       32'd0);
      check("t5_rst_error",    32'(init_error),      32'd0);
      check("t5_rst_checksum", 32'(checksum),        32'd0);
      check("t5_rst_rden",     32'(bus.rom_rden),    32'd0);
      check("t5_rst_rom_addr", 32'(bus.rom_address), 32'h100);
      check("t5_pending",      32'(exp_q.size()),    32'd0);
      repeat (2) @(negedge clock);
      rst_n = 1'b1;
      repeat (4) @(negedge clock);
      check("t5_stay_idle", 32'(o_state),   32'd0);
      check("t5_idle_busy", 32'(init_busy), 32'd0);
      load_rom(8'h11, 8'h22, 8'h33, 8'h44, 4);
      start_load();
      wait_end("t5_end");
      check("t5_done",         32'(init_done),     32'd1);
      check("t5_checksum",     32'(checksum),      32'hAA);
      check("t5_pending_end",  32'(exp_q.size()),  32'd0);
      if (rden_addr_q.size() > 0)
         check("t5_first_addr", 32'(rden_addr_q[0]), 32'h100);

      // 6: CPU writes blocked while busy, start ignored mid-load
      drive_cpu(17'h00055, 1'b1, 8'h77);
      load_rom(8'h01, 8'hFF, 8'h80, 8'h80, 4);
      start_load();
      #1;
      check("t6_block_wren", 32'(bus.ram_wren),    32'd0);
      check("t6_block_addr", 32'(bus.ram_address), 32'h100);
      repeat (6) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      check("t6_busy_mid", 32'(init_busy), 32'd1);
      wait_end("t6_end");
      check("t6_done",     32'(init_done),          32'd1);
      check("t6_checksum", 32'(checksum),           32'h00);
      check("t6_pending",  32'(exp_q.size()),       32'd0);
      check("t6_rden_cnt", 32'(rden_addr_q.size()), 32'd4);
      #1;
      check("t6_pass_wren", 32'(bus.ram_wren),    32'd1);
      check("t6_pass_addr", 32'(bus.ram_address), 32'h00055);
      check("t6_pass_data", 32'(bus.ram_dataout), 32'h77);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
